// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the keyboard-LED step scheduler: key codes,
// scheduler states and the speed level type.
package led_ctrl_pkg;

  localparam logic [3:0] KEY_START_STOP = 4'h1;
  localparam logic [3:0] KEY_FASTER     = 4'h2;
  localparam logic [3:0] KEY_SLOWER     = 4'h3;
  localparam logic [3:0] KEY_REVERSE    = 4'h4;
  localparam logic [3:0] KEY_SINGLE     = 4'h5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  typedef logic [1:0] speed_t;

endpackage

// File: rtl/step_divider.sv
// Loadable prescaler: counts 0..period-1 while enabled and flags the
// terminal count; a clear restarts the count and swallows that terminal count.
module step_divider #(
  parameter int DIV_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] period,
  output logic             tc
);

  logic [DIV_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == (period - DIV_W'(1)));
  assign tc     = en && !clr && w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!en || clr || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/led_step_ctrl.sv
// Step scheduler for the LED rotator: decodes key commands into run/pause
// sequencing, speed and direction, and emits registered one-cycle step pulses.
module led_step_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int BASE_DIV = 50_000_000,
  parameter int DIV_W    = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       step,
  output logic       dir,
  output logic       running,
  output logic [1:0] speed
);

  state_t           r_state;
  state_t           w_stateNext;
  speed_t           r_speed;
  speed_t           w_speedNext;
  logic             r_dir;
  logic             r_revPend;
  logic             r_step;
  logic             w_stepNext;
  logic             w_startStop;
  logic             w_faster;
  logic             w_slower;
  logic             w_reverse;
  logic             w_single;
  logic             w_speedChg;
  logic             w_clr;
  logic             w_tc;
  logic [DIV_W-1:0] w_period;

  assign w_startStop = key_valid && (key_code == KEY_START_STOP);
  assign w_faster    = key_valid && (key_code == KEY_FASTER);
  assign w_slower    = key_valid && (key_code == KEY_SLOWER);
  assign w_reverse   = key_valid && (key_code == KEY_REVERSE);
  assign w_single    = key_valid && (key_code == KEY_SINGLE);

  always_comb begin
    w_speedNext = r_speed;
    if (w_faster && (r_speed != 2'd3)) begin
      w_speedNext = r_speed + 2'd1;
    end else if (w_slower && (r_speed != 2'd0)) begin
      w_speedNext = r_speed - 2'd1;
    end
  end

  // Any START_STOP or real speed change restarts the divider and drops a coincident tc.
  assign w_speedChg = (w_speedNext != r_speed);
  assign w_clr      = w_startStop || w_speedChg;
  assign w_period   = DIV_W'(BASE_DIV >> r_speed);

  step_divider #(
    .DIV_W (DIV_W)
  ) u_divider (
    .clk    (clk),
    .rst    (rst),
    .en     (r_state == RUN),
    .clr    (w_clr),
    .period (w_period),
    .tc     (w_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_stepNext  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_startStop) w_stateNext = RUN;
      end
      RUN: begin
        w_stepNext = w_tc;
        if (w_startStop) w_stateNext = PAUSE;
      end
      PAUSE: begin
        w_stepNext = w_single;
        if (w_startStop) w_stateNext = RUN;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // A REVERSE that coincides with an outgoing step is held back one cycle
  // so the step still carries the old direction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_speed   <= 2'd0;
      r_step    <= 1'b0;
      r_dir     <= 1'b0;
      r_revPend <= 1'b0;
    end else begin
      r_speed   <= w_speedNext;
      r_step    <= w_stepNext;
      r_revPend <= w_reverse && w_stepNext;
      r_dir     <= r_dir ^ r_revPend ^ (w_reverse && !w_stepNext);
    end
  end

  assign step    = r_step;
  assign dir     = r_dir;
  assign running = (r_state == RUN);
  assign speed   = r_speed;

endmodule

// File: tb/tb_led_step_ctrl.sv
// Scoreboard bench for led_step_ctrl: a schedule-based reference model pushes
// the expected outputs of every cycle and a monitor compares them.
module tb_led_step_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       step;
  logic       dir;
  logic       running;
  logic [1:0] speed;

  int checks = 0;
  int errors = 0;

  logic [4:0] expQ[$];

  // Reference model: 0 idle, 1 run, 2 pause; steps fall at runStart + m*P.
  int mState = 0;
  int mSpeed = 0;
  bit mLog = 1'b0;
  int mRunStart = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  led_step_ctrl #(
    .BASE_DIV (8),
    .DIV_W    (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .step      (step),
    .dir       (dir),
    .running   (running),
    .speed     (speed)
  );

  function automatic bit tcNow();
    int p;
    p = 8 >> mSpeed;
    return (mState == 1) && (((cyc - mRunStart + 1) % p) == 0);
  endfunction

  task automatic checkOutput(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d t=%0t: got step=%b dir=%b running=%b speed=%0d, want step=%b dir=%b running=%b speed=%0d",
               name, cyc, $time, act[4], act[3], act[2], act[1:0], exp[4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit v, input logic [3:0] c);
    bit prevRst;
    bit tc, ss, fa, sl, rv, sg, stp, nlog, edir;
    int p, ns, nsp;
    @(negedge clk);
    prevRst   = rst;
    rst       = r;
    key_valid = v;
    key_code  = c;
    if (r) begin
      if (!prevRst) begin
        #1;
        checkOutput("async_reset", {step, dir, running, speed}, 5'b0);
      end
      mState    = 0;
      mSpeed    = 0;
      mLog      = 1'b0;
      mRunStart = 0;
      expQ.push_back(5'b0);
    end else begin
      p   = 8 >> mSpeed;
      tc  = (mState == 1) && (((cyc - mRunStart + 1) % p) == 0);
      ss  = v && (c == 4'h1);
      fa  = v && (c == 4'h2);
      sl  = v && (c == 4'h3);
      rv  = v && (c == 4'h4);
      sg  = v && (c == 4'h5);
      nsp = fa ? ((mSpeed < 3) ? mSpeed + 1 : 3) : (sl ? ((mSpeed > 0) ? mSpeed - 1 : 0) : mSpeed);
      stp = ((mState == 1) && tc && !ss && (nsp == mSpeed)) || ((mState == 2) && sg);
      ns  = ss ? ((mState == 1) ? 2 : 1) : mState;
      if ((ns == 1) && (ss || (nsp != mSpeed))) mRunStart = cyc + 1;
      nlog = mLog ^ rv;
      edir = (rv && stp) ? mLog : nlog;
      expQ.push_back({stp, edir, (ns == 1), 2'(nsp)});
      mState = ns;
      mSpeed = nsp;
      mLog   = nlog;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 4'h0);
  endtask

  task automatic key(input logic [3:0] c);
    applyStimulus(1'b0, 1'b1, c);
  endtask

  initial begin : monitor
    logic [4:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("cycle", {step, dir, running, speed}, e);
      end
    end
  end

  initial begin : stimulus
    bit found;
    bit r;
    bit v;
    logic [3:0] c;

    repeat (3) applyStimulus(1'b1, 1'b0, 4'h0);
    idle(100);

    key(4'h1);
    idle(30);

    repeat (3) begin
      key(4'h2);
      idle(3);
    end
    key(4'h2);
    idle(10);

    repeat (3) begin
      key(4'h3);
      idle(2);
    end
    key(4'h1);
    idle(3);
    key(4'h5);
    idle(4);
    key(4'h5);
    idle(5);
    key(4'h1);
    idle(3);
    key(4'h5);
    idle(12);

    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tcNow()) begin
        key(4'h4);
        found = 1'b1;
        break;
      end
      idle(1);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL reverse_at_tc: got no terminal count within 20 cycles, want one");
    end
    idle(20);

    key(4'h2);
    key(4'h2);
    idle(3);
    applyStimulus(1'b1, 1'b0, 4'h0);
    idle(20);
    key(4'h1);
    idle(10);

    repeat (1500) begin
      r = ($urandom_range(0, 299) == 0);
      v = ($urandom_range(0, 2) == 0);
      c = 4'($urandom_range(0, 7));
      if (r) applyStimulus(1'b1, 1'b0, 4'h0);
      else   applyStimulus(1'b0, v, c);
    end

    idle(2);
    @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
